dcache_wt: RTL and testbench

Direct-mapped, write-through data cache between the single-cycle core's ALU/store-data path and the fixed-latency byte-lane main memory. It accepts one word request at a time and holds the core with `done` low until the request completes. Read hits complete without a memory access; read misses and all writes take `MEM_LAT` memory cycles. The memory side uses the same four-byte-lane big-endian array as the core's memory port.

---
 rtl/dcache_pkg.sv | 27 ++
 rtl/dcache_store.sv | 47 ++++
 rtl/dcache_wt.sv | 145 ++++++++++++++
 tb/tb_dcache_wt.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the write-through data cache.
// Byte lanes are big-endian: lane 0 carries bits [31:24].
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM_RD = 2'd1,
        MEM_WR = 2'd2,
        RESP   = 2'd3
    } dcache_state_t;

    typedef logic [7:0] byte_lanes_t [0:3];

    function automatic logic [31:0] lanes_to_word(input byte_lanes_t l);
        return {l[0], l[1], l[2], l[3]};
    endfunction

    function automatic void word_to_lanes(
        input  logic [31:0] w,
        output byte_lanes_t l
    );
        for (int i = 0; i < 4; i++) begin
            l[i] = w[31-8*i -: 8];
        end
    endfunction

endpackage

// File: rtl/dcache_store.sv
// Valid/tag/data arrays for the direct-mapped cache.
// Combinational read port, synchronous write port; only valid bits reset.
module dcache_store
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    // Valid bits: cleared by reset, set when a line is filled.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage: no reset, guarded by the valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through data cache with fixed-latency memory.
// Holds the core with done low until each request completes.
module dcache_wt
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int MEM_LAT   = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rsp_rdata,
    output logic        done,
    output logic [31:0] mem_addr,
    output byte_lanes_t mem_data_in,
    input  byte_lanes_t mem_data_out,
    output logic        mem_write_en
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 30 - IDX_W;
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    dcache_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rsp_q;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit;
    logic             in_mem;
    logic             line_wr;
    logic [31:0]      wr_word;
    logic             start_mem;
    logic             start_hit;
    byte_lanes_t      wr_lanes;

    assign req_idx = req_addr[IDX_W+1:2];
    assign req_tag = req_addr[31:IDX_W+2];
    assign hit     = rd_valid && (rd_tag == req_tag);
    assign in_mem  = (state_q == MEM_RD) || (state_q == MEM_WR);
    assign line_wr = in_mem && (cnt_q == '0);

    assign start_hit = (state_q == IDLE) && req_valid && !req_write && hit;
    assign start_mem = (state_q == IDLE) && req_valid && (req_write || !hit);

    assign wr_word = (state_q == MEM_WR) ? req_wdata
                                         : lanes_to_word(mem_data_out);

    dcache_store #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_store (
        .clk      (clk),
        .rst_b    (rst_b),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (line_wr),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_data  (wr_word)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: hits respond next cycle, misses and stores go to memory.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_write) begin
                        state_d = MEM_WR;
                    end else if (hit) begin
                        state_d = RESP;
                    end else begin
                        state_d = MEM_RD;
                    end
                end
            end
            MEM_RD, MEM_WR: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latency counter and response register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
            rsp_q <= '0;
        end else begin
            if (start_mem) begin
                cnt_q <= CNT_INIT;
            end else if (in_mem && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (start_hit) begin
                rsp_q <= rd_data;
            end else if (line_wr) begin
                rsp_q <= wr_word;
            end
        end
    end

    // Store data split into memory byte lanes.
    always_comb begin
        word_to_lanes(req_wdata, wr_lanes);
    end

    // Memory-side outputs: lanes only driven during a store.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_data_in[i] = (state_q == MEM_WR) ? wr_lanes[i] : 8'h00;
        end
    end

    assign mem_write_en = (state_q == MEM_WR);
    assign mem_addr     = req_addr & 32'hFFFF_FFFC;
    assign done         = (state_q == RESP);
    assign rsp_rdata    = (state_q == RESP) ? rsp_q : 32'h0;

endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt: directed scenarios plus random traffic.
// Reference is a word-level cache/memory model kept in plain arrays.
module tb_dcache_wt;
    import dcache_pkg::*;

    logic        clk;
    logic        rst_b;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rsp_rdata;
    logic        done;
    logic [31:0] mem_addr;
    byte_lanes_t mem_data_in;
    byte_lanes_t mem_data_out;
    logic        mem_write_en;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    bit          ref_v   [16];
    int          ref_t   [16];

    dcache_wt #(.NUM_LINES(16), .MEM_LAT(4)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_rdata    (rsp_rdata),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_write_en (mem_write_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory read side: word presented on the byte lanes at all times.
    always_comb begin
        logic [31:0] w;
        w = mem[mem_addr[9:2]];
        mem_data_out[0] = w[31:24];
        mem_data_out[1] = w[23:16];
        mem_data_out[2] = w[15:8];
        mem_data_out[3] = w[7:0];
    end

    // Issue one request; report latency, data, write-strobe cycles.
    task automatic do_req(
        input  bit          wr,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        output int          lat,
        output logic [31:0] rdata,
        output int          we_cnt,
        output logic [31:0] lanes,
        output int          addr_bad
    );
        lat      = -1;
        rdata    = 32'h0;
        we_cnt   = 0;
        lanes    = 32'h0;
        addr_bad = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_addr !== {addr[31:2], 2'b00}) addr_bad++;
            if (mem_write_en === 1'b1) begin
                if (we_cnt == 0)
                    lanes = {mem_data_in[0], mem_data_in[1],
                             mem_data_in[2], mem_data_in[3]};
                mem[mem_addr[9:2]] = {mem_data_in[0], mem_data_in[1],
                                      mem_data_in[2], mem_data_in[3]};
                we_cnt++;
            end
            if (done === 1'b1) begin
                lat   = k;
                rdata = rsp_rdata;
                break;
            end
        end
        req_valid = 1'b0;
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout addr=%h: no done within 20 cycles", addr);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            ref_v[i] = 1'b0;
            ref_t[i] = 0;
        end
    endtask

    task automatic test_reset();
        rst_b     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0000_0123;
        req_wdata = 32'h5555_AAAA;
        repeat (3) @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done got=%b want=0", done);
        end
        n_checks++;
        if (rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata got=%h want=0", rsp_rdata);
        end
        n_checks++;
        if (mem_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_we got=%b want=0", mem_write_en);
        end
        n_checks++;
        if ({mem_data_in[0], mem_data_in[1], mem_data_in[2],
             mem_data_in[3]} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data_in got=%h%h%h%h want=0",
                     mem_data_in[0], mem_data_in[1],
                     mem_data_in[2], mem_data_in[3]);
        end
        n_checks++;
        if (mem_addr !== 32'h0000_0120) begin
            n_fail++;
            $display("FAIL reset_mem_addr got=%h want=00000120", mem_addr);
        end
        rst_b = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_miss_hit();
        int lat, we, bad;
        logic [31:0] rd, ln;
        do_req(1'b0, 32'h40, 32'h0, lat, rd, we, ln, bad);
        n_checks++;
        if (lat != 5) begin
            n_fail++;
            $display("FAIL miss_lat got=%0d want=5", lat);
        end
        n_checks++;
        if (rd !== 32'h1122_3344) begin
            n_fail++;
            $display("FAIL miss_data got=%h want=11223344", rd);
        end
        n_checks++;
        if (we != 0) begin
            n_fail++;
            $display("FAIL miss_we got=%0d want=0", we);
        end
        do_req(1'b0, 32'h40, 32'h0, lat, rd, we, ln, bad);
        n_checks++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL hit_lat got=%0d want=1", lat);
        end
        n_checks++;
        if (rd !== 32'h1122_3344) begin
            n_fail++;
            $display("FAIL hit_data got=%h want=11223344", rd);
        end
    endtask

    task automatic test_store();
        int lat, we, bad;
        logic [31:0] rd, ln;
        do_req(1'b1, 32'h80, 32'hDEAD_BEEF, lat, rd, we, ln, bad);
        ref_mem[32'h80 >> 2] = 32'hDEAD_BEEF;
        n_checks++;
        if (we != 4) begin
            n_fail++;
            $display("FAIL store_we got=%0d want=4", we);
        end
        n_checks++;
        if (ln !== {8'hDE, 8'hAD, 8'hBE, 8'hEF}) begin
            n_fail++;
            $display("FAIL store_lanes got=%h want=deadbeef", ln);
        end
        n_checks++;
        if (lat != 5) begin
            n_fail++;
            $display("FAIL store_lat got=%0d want=5", lat);
        end
        n_checks++;
        if (mem[32'h80 >> 2] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL store_mem got=%h want=deadbeef", mem[32'h80 >> 2]);
        end
        do_req(1'b0, 32'h80, 32'h0, lat, rd, we, ln, bad);
        n_checks++;
        if (lat != 1 || rd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL store_hit got=%0d/%h want=1/deadbeef", lat, rd);
        end
    endtask

    task automatic test_index_wrap();
        int lat, we, bad;
        logic [31:0] rd, ln;
        do_req(1'b0, 32'h00, 32'h0, lat, rd, we, ln, bad);
        n_checks++;
        if (lat != 5 || rd !== ref_mem[0]) begin
            n_fail++;
            $display("FAIL wrap0 got=%0d/%h want=5/%h", lat, rd, ref_mem[0]);
        end
        do_req(1'b0, 32'h40, 32'h0, lat, rd, we, ln, bad);
        n_checks++;
        if (lat != 5 || rd !== 32'h1122_3344) begin
            n_fail++;
            $display("FAIL wrap40 got=%0d/%h want=5/11223344", lat, rd);
        end
        do_req(1'b0, 32'h00, 32'h0, lat, rd, we, ln, bad);
        n_checks++;
        if (lat != 5) begin
            n_fail++;
            $display("FAIL wrap0_again got=%0d want=5", lat);
        end
    endtask

    task automatic test_reset_mid();
        int lat, we, bad, late_done;
        logic [31:0] rd, ln;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'hC0;
        req_wdata = 32'hCAFE_F00D;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            if (mem_write_en === 1'b1)
                mem[mem_addr[9:2]] = {mem_data_in[0], mem_data_in[1],
                                      mem_data_in[2], mem_data_in[3]};
        end
        n_checks++;
        if (mem_write_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_we_before got=%b want=1", mem_write_en);
        end
        #2;
        rst_b = 1'b0;
        #1;
        n_checks++;
        if (mem_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_we_drop got=%b want=0", mem_write_en);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_done got=%b want=0", done);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        late_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b0) late_done++;
        end
        n_checks++;
        if (late_done != 0) begin
            n_fail++;
            $display("FAIL rstmid_late_done got=%0d want=0", late_done);
        end
        ref_mem[32'hC0 >> 2] = mem[32'hC0 >> 2];
        model_clear();
        do_req(1'b0, 32'h40, 32'h0, lat, rd, we, ln, bad);
        n_checks++;
        if (lat != 5 || rd !== 32'h1122_3344) begin
            n_fail++;
            $display("FAIL rstmid_reload got=%0d/%h want=5/11223344", lat, rd);
        end
    endtask

    task automatic test_random();
        int lat, we, bad, idx, tag, exp_lat, exp_we;
        logic [31:0] rd, ln, addr, wd, exp_rd;
        bit wr;
        for (int n = 0; n < 80; n++) begin
            addr = ($urandom_range(0, 63) * 4) | $urandom_range(0, 3);
            wr   = ($urandom_range(0, 2) == 0);
            wd   = $urandom;
            idx  = (addr / 4) % 16;
            tag  = addr / 64;
            if (wr) begin
                exp_lat = 5;
                exp_we  = 4;
                exp_rd  = wd;
                ref_mem[addr / 4] = wd;
            end else begin
                exp_lat = (ref_v[idx] && ref_t[idx] == tag) ? 1 : 5;
                exp_we  = 0;
                exp_rd  = ref_mem[addr / 4];
            end
            ref_v[idx] = 1'b1;
            ref_t[idx] = tag;
            do_req(wr, addr, wd, lat, rd, we, ln, bad);
            n_checks++;
            if (lat != exp_lat) begin
                n_fail++;
                $display("FAIL rnd_lat n=%0d addr=%h got=%0d want=%0d",
                         n, addr, lat, exp_lat);
            end
            n_checks++;
            if (rd !== exp_rd) begin
                n_fail++;
                $display("FAIL rnd_data n=%0d addr=%h got=%h want=%h",
                         n, addr, rd, exp_rd);
            end
            n_checks++;
            if (we != exp_we || bad != 0) begin
                n_fail++;
                $display("FAIL rnd_mem n=%0d addr=%h we=%0d/%0d badaddr=%0d",
                         n, addr, we, exp_we, bad);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = (i * 32'h0101_0101) ^ 32'hA5C3_0F96;
            ref_mem[i] = (i * 32'h0101_0101) ^ 32'hA5C3_0F96;
        end
        mem[32'h40 >> 2]     = 32'h1122_3344;
        ref_mem[32'h40 >> 2] = 32'h1122_3344;
        test_reset();
        test_miss_hit();
        test_store();
        test_index_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
